// File: rtl/insn_bundle_packer.sv
// Packs 16-bit instruction parcels into 15-parcel predecoded bundles with a one-parcel tail.
// A length walker marks instruction starts/ends as parcels arrive; output reads buffer entries 0..15.
module insn_bundle_packer #(
    parameter int unsigned BUFD = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic [2:0]   in_cnt,
    input  logic         in_fault,
    input  logic         in_avx,
    input  logic         in_flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] bundle,
    output logic [16:0]  btail,
    output logic [14:0]  flag_bits,
    output logic [3:0]   start_off,
    output logic         len_err
);
    localparam int unsigned CW = $clog2(BUFD + 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      rem_q, rem_d;
    logic            flush_pend_q, flush_pend_d;
    logic [15:0]     par_q [BUFD];
    logic [15:0]     par_d [BUFD];
    logic [BUFD-1:0] end_q, end_d, st_q, st_d, flt_q, flt_d, err_q, err_d, avx_q, avx_d;

    logic       cnt_ok, push, pop, flush_pop;
    logic [3:0] w_st, w_end, w_err;
    logic [2:0] w_rem, r, code, len;
    logic       bad;
    logic [CW-1:0] idx;

    assign cnt_ok    = (in_cnt != 3'd0) && (in_cnt <= 3'd4);
    assign in_ready  = (cnt_q <= CW'(BUFD - 4)) & ~flush_pend_q;
    assign out_valid = (cnt_q >= CW'(16)) | (flush_pend_q & (cnt_q != '0));
    assign push      = in_valid & in_ready & cnt_ok;
    assign pop       = out_valid & out_ready;
    assign flush_pop = pop & (cnt_q < CW'(16));

    // Length walker: chains up to four parcels of the beat in arrival order.
    always_comb begin
        r     = rem_q;
        code  = '0;
        len   = '0;
        bad   = 1'b0;
        w_st  = '0;
        w_end = '0;
        w_err = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < in_cnt) begin
                code     = in_data[16*k +: 3];
                bad      = code > 3'd4;
                len      = bad ? 3'd1 : code + 3'd1;
                w_st[k]  = (r == 3'd0);
                w_err[k] = w_st[k] & bad;
                r        = w_st[k] ? len - 3'd1 : r - 3'd1;
                w_end[k] = (r == 3'd0);
            end
        end
        w_rem = r;
    end

    always_comb begin
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        flush_pend_d = flush_pend_q;
        par_d        = par_q;
        end_d        = end_q;
        st_d         = st_q;
        flt_d        = flt_q;
        err_d        = err_q;
        avx_d        = avx_q;
        idx          = '0;
        if (in_flush && cnt_q != '0) flush_pend_d = 1'b1;
        if (pop) begin
            if (flush_pop) begin
                cnt_d        = '0;
                rem_d        = 3'd0;
                flush_pend_d = 1'b0;
            end else begin
                // Old entry 15 becomes entry 0; the walker state carries over.
                for (int i = 0; i < int'(BUFD) - 15; i++) par_d[i] = par_q[i+15];
                end_d = end_q >> 15;
                st_d  = st_q >> 15;
                flt_d = flt_q >> 15;
                err_d = err_q >> 15;
                avx_d = avx_q >> 15;
                cnt_d = cnt_q - CW'(15);
            end
        end
        if (push) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < in_cnt) begin
                    idx        = cnt_d + CW'(k);
                    par_d[idx] = in_data[16*k +: 16];
                    end_d[idx] = w_end[k];
                    st_d[idx]  = w_st[k];
                    flt_d[idx] = in_fault;
                    err_d[idx] = w_err[k];
                    avx_d[idx] = in_avx;
                end
            end
            cnt_d = cnt_d + CW'(in_cnt);
            rem_d = w_rem;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            rem_q        <= 3'd0;
            flush_pend_q <= 1'b0;
            par_q        <= '{default: '0};
            end_q        <= '0;
            st_q         <= '0;
            flt_q        <= '0;
            err_q        <= '0;
            avx_q        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            flush_pend_q <= flush_pend_d;
            par_q        <= par_d;
            end_q        <= end_d;
            st_q         <= st_d;
            flt_q        <= flt_d;
            err_q        <= err_d;
            avx_q        <= avx_d;
        end
    end

    logic        v, pad, e;
    logic [15:0] p;
    logic [15:0] show_st;

    // Unfilled slots read as zero, or as padding one-parcel instructions during a flush.
    always_comb begin
        bundle    = '0;
        btail     = '0;
        flag_bits = '0;
        len_err   = 1'b0;
        show_st   = '0;
        start_off = 4'd15;
        v         = 1'b0;
        pad       = 1'b0;
        e         = 1'b0;
        p         = '0;
        for (int i = 0; i < 16; i++) begin
            v          = CW'(i) < cnt_q;
            pad        = ~v & flush_pend_q;
            p          = v ? par_q[i] : 16'h0;
            e          = v ? end_q[i] : pad;
            show_st[i] = v ? st_q[i] : pad;
            len_err    = len_err | (v & err_q[i]);
            if (i < 15) begin
                bundle[16*i +: 16] = p;
                bundle[240 + i]    = e;
                flag_bits[i]       = v & flt_q[i];
            end else begin
                btail = {e, p};
            end
        end
        for (int i = 14; i >= 0; i--) begin
            if (show_st[i]) start_off = 4'(i);
        end
        bundle[255] = (cnt_q != '0) & avx_q[0];
    end

endmodule

// File: tb/tb_insn_bundle_packer.sv
// Directed bench for insn_bundle_packer: reset, spanning instructions, backpressure,
// flush padding, illegal length codes, fault/mode flags and asynchronous reset.
module tb_insn_bundle_packer;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_data = '0;
    logic [2:0]   in_cnt = 3'd0;
    logic         in_fault = 1'b0;
    logic         in_avx = 1'b0;
    logic         in_flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] bundle;
    logic [16:0]  btail;
    logic [14:0]  flag_bits;
    logic [3:0]   start_off;
    logic         len_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] pl [64];

    insn_bundle_packer #(.BUFD(20)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_cnt(in_cnt), .in_fault(in_fault), .in_avx(in_avx),
        .in_flush(in_flush), .out_valid(out_valid), .out_ready(out_ready),
        .bundle(bundle), .btail(btail), .flag_bits(flag_bits),
        .start_off(start_off), .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int id, input int code);
        return {13'(id), 3'(code)};
    endfunction

    task automatic init_pl();
        for (int i = 0; i < 64; i++) pl[i] = mk(i, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0; in_flush = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        init_pl();
    endtask

    task automatic send(input logic [63:0] d, input logic [2:0] n, input logic f, input logic a);
        int t;
        @(negedge clk);
        in_data = d; in_cnt = n; in_fault = f; in_avx = a; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 256'(in_ready), 256'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic feed(input int from, input int num, input logic f, input logic a);
        int n;
        logic [63:0] d;
        for (int b = from; b < from + num; b += 4) begin
            n = (from + num - b) < 4 ? (from + num - b) : 4;
            d = '0;
            for (int j = 0; j < n; j++) d[16*j +: 16] = pl[b+j];
            send(d, 3'(n), f, a);
        end
    endtask

    task automatic pop_one();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        init_pl();
        // Reset state
        #3;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_start_off", 256'(start_off), 256'(15));
        check("rst_bundle", bundle, 256'(0));
        check("rst_btail", 256'(btail), 256'(0));
        check("rst_flags", 256'(flag_bits), 256'(0));
        check("rst_len_err", 256'(len_err), 256'(0));
        #2 rst = 1'b1;

        // Sixteen one-parcel instructions
        feed(0, 16, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_valid", 256'(out_valid), 256'(1));
        check("t1_ends", 256'(bundle[254:240]), 256'(15'h7FFF));
        check("t1_tail_end", 256'(btail[16]), 256'(1));
        check("t1_tail_par", 256'(btail[15:0]), 256'(16'h0078));
        check("t1_par1", 256'(bundle[31:16]), 256'(16'h0008));
        check("t1_start_off", 256'(start_off), 256'(0));
        pop_one();
        @(negedge clk);
        check("t1_cnt_after_pop", 256'(dut.cnt_q), 256'(1));
        check("t1_valid_after_pop", 256'(out_valid), 256'(0));
        check("t1_new_entry0", 256'(bundle[15:0]), 256'(16'h0078));

        // Spanning: lengths 5,5,5,3
        do_reset();
        pl[0] = mk(0, 4); pl[5] = mk(5, 4); pl[10] = mk(10, 4); pl[15] = mk(15, 2);
        feed(0, 16, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_ends", 256'(bundle[254:240]), 256'(15'h4210));
        check("t2_tail", 256'(btail), 256'(17'h0007A));
        check("t2_start_off", 256'(start_off), 256'(0));
        pop_one();
        feed(16, 15, 1'b0, 1'b0);
        @(negedge clk);
        check("t2b_valid", 256'(out_valid), 256'(1));
        check("t2b_ends", 256'(bundle[254:240]), 256'(15'h7FFC));
        check("t2b_start_off", 256'(start_off), 256'(0));
        check("t2b_tail_end", 256'(btail[16]), 256'(1));

        // Spanning: lengths 4,4,4,4
        do_reset();
        pl[0] = mk(0, 3); pl[4] = mk(4, 3); pl[8] = mk(8, 3); pl[12] = mk(12, 3);
        feed(0, 16, 1'b0, 1'b0);
        @(negedge clk);
        check("t3_ends", 256'(bundle[254:240]), 256'(15'h0888));
        check("t3_tail_end", 256'(btail[16]), 256'(1));
        pop_one();
        feed(16, 15, 1'b0, 1'b0);
        @(negedge clk);
        check("t3b_start_off", 256'(start_off), 256'(1));
        check("t3b_ends", 256'(bundle[254:240]), 256'(15'h7FFF));

        // Backpressure
        do_reset();
        feed(0, 20, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_cnt20", 256'(dut.cnt_q), 256'(20));
        check("bp_in_ready", 256'(in_ready), 256'(0));
        check("bp_valid", 256'(out_valid), 256'(1));
        in_data = {4{mk(99, 0)}}; in_cnt = 3'd4; in_valid = 1'b1;
        repeat (10) @(negedge clk);
        check("bp_hold_cnt", 256'(dut.cnt_q), 256'(20));
        check("bp_hold_par1", 256'(bundle[31:16]), 256'(16'h0008));
        check("bp_hold_tail", 256'(btail), 256'(17'h10078));
        check("bp_hold_ready", 256'(in_ready), 256'(0));
        in_valid = 1'b0;
        pop_one();
        @(negedge clk);
        check("bp_pop_cnt", 256'(dut.cnt_q), 256'(5));
        check("bp_pop_entry0", 256'(bundle[15:0]), 256'(16'h0078));
        feed(20, 11, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_cnt16_valid", 256'(out_valid), 256'(1));
        check("bp_cnt16_ready", 256'(in_ready), 256'(1));
        in_data = {pl[34], pl[33], pl[32], pl[31]}; in_cnt = 3'd4; in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("bp_pushpop_cnt", 256'(dut.cnt_q), 256'(5));
        check("bp_pushpop_e0", 256'(bundle[15:0]), 256'(16'h00F0));
        check("bp_pushpop_e4", 256'(bundle[79:64]), 256'(16'h0110));

        // Flush with empty buffer is a no-op
        do_reset();
        @(negedge clk);
        in_flush = 1'b1;
        @(posedge clk);
        #1 in_flush = 1'b0;
        @(negedge clk);
        check("fl_empty_valid", 256'(out_valid), 256'(0));
        check("fl_empty_ready", 256'(in_ready), 256'(1));

        // Flush of a partial bundle: lengths 2,2,2
        pl[0] = mk(0, 1); pl[2] = mk(2, 1); pl[4] = mk(4, 1);
        feed(0, 6, 1'b0, 1'b0);
        @(negedge clk);
        in_flush = 1'b1;
        @(posedge clk);
        #1 in_flush = 1'b0;
        @(negedge clk);
        check("fl_valid", 256'(out_valid), 256'(1));
        check("fl_ready", 256'(in_ready), 256'(0));
        check("fl_ends", 256'(bundle[254:240]), 256'(15'h7FEA));
        check("fl_pad_pars", 256'(bundle[239:96]), 256'(0));
        check("fl_tail", 256'(btail), 256'(17'h10000));
        check("fl_par0", 256'(bundle[15:0]), 256'(16'h0001));
        pop_one();
        @(negedge clk);
        check("fl_cnt0", 256'(dut.cnt_q), 256'(0));
        check("fl_post_valid", 256'(out_valid), 256'(0));
        check("fl_post_start", 256'(start_off), 256'(15));

        // Illegal code 7 at parcel 3
        do_reset();
        pl[3] = mk(3, 7); pl[4] = mk(4, 1);
        feed(0, 16, 1'b0, 1'b0);
        @(negedge clk);
        check("ill_len_err", 256'(len_err), 256'(1));
        check("ill_ends", 256'(bundle[254:240]), 256'(15'h7FEF));
        pop_one();
        feed(16, 15, 1'b0, 1'b0);
        @(negedge clk);
        check("ill_next_len_err", 256'(len_err), 256'(0));
        check("ill_next_valid", 256'(out_valid), 256'(1));

        // Fault and mode
        do_reset();
        feed(0, 4, 1'b0, 1'b1);
        feed(4, 4, 1'b1, 1'b0);
        feed(8, 4, 1'b0, 1'b0);
        feed(12, 4, 1'b0, 1'b0);
        @(negedge clk);
        check("fm_flags", 256'(flag_bits), 256'(15'h00F0));
        check("fm_avx", 256'(bundle[255]), 256'(1));

        // Asynchronous reset mid-fill
        do_reset();
        feed(0, 4, 1'b0, 1'b1);
        feed(4, 4, 1'b1, 1'b0);
        check("ar_pre_flags", 256'(flag_bits), 256'(15'h00F0));
        #1 rst = 1'b0;
        #1;
        check("ar_bundle", bundle, 256'(0));
        check("ar_flags", 256'(flag_bits), 256'(0));
        check("ar_start_off", 256'(start_off), 256'(15));
        check("ar_in_ready", 256'(in_ready), 256'(1));
        check("ar_valid", 256'(out_valid), 256'(0));
        #1 rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
